// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store controller: funct3 codes, access sizes,
// FSM states and the natural-alignment check.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MERGE_WR = 2'd1,
    RESP     = 2'd2
  } state_e;

  // Every access must be naturally aligned to its own size.
  function automatic logic misaligned(input size_e sz, input logic [2:0] off);
    case (sz)
      SZ_B:    return 1'b0;
      SZ_H:    return off[0];
      SZ_W:    return off[1:0] != 2'b00;
      default: return off != 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane datapath: extracts/extends a load from an 8-byte dword and merges a
// narrow store into a dword read back from memory.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [XLEN-1:0] wdata,
  input  logic [2:0]      off,
  input  size_e           size,
  input  logic            sgn,
  output logic [XLEN-1:0] ext_data,
  output logic [XLEN-1:0] merge_data
);

  logic [5:0]      sh_amt;
  logic [XLEN-1:0] rsh;
  logic [XLEN-1:0] wsh;
  logic [XLEN-1:0] size_mask;
  logic [XLEN-1:0] lane_mask;

  assign sh_amt = {off, 3'b000};

  always_comb begin
    rsh       = rdata >> sh_amt;
    ext_data  = rsh;
    size_mask = '1;
    case (size)
      SZ_B: begin
        ext_data  = {{(XLEN-8){sgn & rsh[7]}}, rsh[7:0]};
        size_mask = {{(XLEN-8){1'b0}}, 8'hFF};
      end
      SZ_H: begin
        ext_data  = {{(XLEN-16){sgn & rsh[15]}}, rsh[15:0]};
        size_mask = {{(XLEN-16){1'b0}}, 16'hFFFF};
      end
      SZ_W: begin
        ext_data  = {{(XLEN-32){sgn & rsh[31]}}, rsh[31:0]};
        size_mask = {{(XLEN-32){1'b0}}, 32'hFFFF_FFFF};
      end
      default: begin
        ext_data  = rsh;
        size_mask = '1;
      end
    endcase
    // Alignment is enforced upstream, so the shifted mask never wraps past byte 7.
    lane_mask  = size_mask << sh_amt;
    wsh        = wdata << sh_amt;
    merge_data = (rdata & ~lane_mask) | (wsh & lane_mask);
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Single-outstanding load/store controller in front of a 64-bit data memory,
// with read-modify-write for sub-dword stores and fault detection at accept.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = 64,
  parameter int XLEN      = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_load,
  input  logic            req_store,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic            mem_write,
  output logic            mem_read,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            resp_valid,
  output logic            resp_fault,
  output logic [XLEN-1:0] load_data
);

  state_e          state, state_nxt;
  logic [XLEN-1:0] addr_hold;
  logic [XLEN-1:0] merge_hold;
  logic [XLEN-1:0] ext_data;
  logic [XLEN-1:0] merge_data;
  logic [XLEN-1:0] addr_aligned;
  logic [2:0]      off;
  size_e           size;
  logic            sgn;
  logic            f3_bad;
  logic            fault;
  logic            accept;
  logic            is_sd;

  assign off          = req_addr[2:0];
  assign size         = size_e'(req_funct3[1:0]);
  assign sgn          = ~req_funct3[2];
  assign addr_aligned = {req_addr[XLEN-1:3], 3'b000};
  assign is_sd        = req_store & (size == SZ_D);

  // Stores only have 000..011; loads reject the unused 111 encoding.
  assign f3_bad = req_store ? req_funct3[2] : (req_funct3 == 3'b111);
  assign fault  = (req_load & req_store) | f3_bad | misaligned(size, off)
                | (req_addr >= XLEN'(MEM_BYTES));

  // Readiness is exactly "in IDLE", so accept is formed from state directly.
  assign accept = req_valid & (state == IDLE) & (req_load | req_store);

  lsu_align #(.XLEN(XLEN)) u_align (
    .rdata      (mem_rdata),
    .wdata      (req_wdata),
    .off        (off),
    .size       (size),
    .sgn        (sgn),
    .ext_data   (ext_data),
    .merge_data (merge_data)
  );

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = addr_hold;
    mem_wdata  = merge_hold;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        mem_addr  = addr_aligned;
        mem_wdata = req_wdata;
        if (accept) begin
          if (fault) begin
            state_nxt = RESP;
          end else if (req_load) begin
            mem_read  = 1'b1;
            state_nxt = RESP;
          end else if (is_sd) begin
            mem_write = 1'b1;
            state_nxt = RESP;
          end else begin
            mem_read  = 1'b1;
            state_nxt = MERGE_WR;
          end
        end
      end
      MERGE_WR: begin
        mem_write = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      addr_hold  <= '0;
      merge_hold <= '0;
      load_data  <= '0;
      resp_fault <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        addr_hold  <= addr_aligned;
        merge_hold <= merge_data;
        resp_fault <= fault;
        if (fault)         load_data <= '0;
        else if (req_load) load_data <= ext_data;
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a behavioural 64-byte data memory.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_load, req_store;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr, req_wdata;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_write, mem_read;
  logic        resp_valid, resp_fault;
  logic [63:0] load_data;

  logic [63:0] mem [8];
  logic        preload;

  int n_tests = 0;
  int n_fail  = 0;

  // Observations from the last run_req call
  logic        acc_ready, acc_read, acc_write;
  logic [63:0] acc_addr;
  int          lat, wr_cyc, wr_seen, rd_post;
  logic [63:0] wr_addr, wr_data;
  logic        r_fault;
  logic [63:0] r_data;
  int          hits;

  lsu_mem_ctrl #(.MEM_BYTES(64), .XLEN(64)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_load(req_load), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_write(mem_write), .mem_read(mem_read), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_fault(resp_fault), .load_data(load_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 8; i++) mem[i] <= '0;
      mem[2] <= 64'h8877_6655_4433_2211;
    end else if (mem_write && mem_addr < 64) begin
      mem[mem_addr[5:3]] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr[5:3]];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic ld, input logic st,
                       input logic [2:0] f3, input logic [63:0] a, input logic [63:0] wd);
    req_valid  = v;
    req_load   = ld;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
  endtask

  // Issue one request, then watch up to 4 cycles for memory activity and the response.
  task automatic run_req(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [63:0] a, input logic [63:0] wd);
    @(negedge clk);
    drive(1'b1, ld, st, f3, a, wd);
    #1;
    acc_ready = req_ready;
    acc_read  = mem_read;
    acc_write = mem_write;
    acc_addr  = mem_addr;
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 3'b000, 64'h0, 64'h0);
    lat = 0; wr_cyc = 0; wr_seen = 0; rd_post = 0;
    wr_addr = '0; wr_data = '0; r_fault = 1'bx; r_data = 'x;
    for (int i = 1; i <= 4; i++) begin
      #1;
      if (mem_write) begin
        wr_seen++;
        wr_cyc  = i;
        wr_addr = mem_addr;
        wr_data = mem_wdata;
      end
      if (mem_read) rd_post++;
      if (resp_valid) begin
        lat     = i;
        r_fault = resp_fault;
        r_data  = load_data;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_load(input string tag, input logic [63:0] exp);
    check({tag, "_ready"}, 64'(acc_ready), 64'd1);
    check({tag, "_rd"},    64'(acc_read),  64'd1);
    check({tag, "_wr"},    64'(acc_write) + 64'(wr_seen), 64'd0);
    check({tag, "_lat"},   64'(lat), 64'd1);
    check({tag, "_flt"},   64'(r_fault), 64'd0);
    check({tag, "_data"},  r_data, exp);
  endtask

  task automatic check_fault(input string tag);
    check({tag, "_mem"},  64'(acc_read) + 64'(acc_write) + 64'(wr_seen) + 64'(rd_post), 64'd0);
    check({tag, "_lat"},  64'(lat), 64'd1);
    check({tag, "_flt"},  64'(r_fault), 64'd1);
    check({tag, "_data"}, r_data, 64'd0);
  endtask

  initial begin
    reset   = 1'b0;
    preload = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 3'b000, 64'h0, 64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_ready", 64'(req_ready),  64'd1);
    check("rst_mrd",   64'(mem_read),   64'd0);
    check("rst_mwr",   64'(mem_write),  64'd0);
    check("rst_rv",    64'(resp_valid), 64'd0);
    check("rst_flt",   64'(resp_fault), 64'd0);
    check("rst_ld",    load_data,       64'd0);
    preload = 1'b0;
    reset   = 1'b1;

    run_req(1'b1, 1'b0, 3'b000, 64'h17, 64'h0);
    check_load("lb17", 64'hFFFF_FFFF_FFFF_FF88);
    check("lb17_addr", acc_addr, 64'h10);
    run_req(1'b1, 1'b0, 3'b101, 64'h16, 64'h0);
    check_load("lhu16", 64'h0000_0000_0000_8877);
    run_req(1'b1, 1'b0, 3'b010, 64'h14, 64'h0);
    check_load("lw14", 64'hFFFF_FFFF_8877_6655);
    run_req(1'b1, 1'b0, 3'b011, 64'h10, 64'h0);
    check_load("ld10", 64'h8877_6655_4433_2211);
    run_req(1'b1, 1'b0, 3'b100, 64'h13, 64'h0);
    check_load("lbu13", 64'h0000_0000_0000_0044);

    run_req(1'b1, 1'b0, 3'b010, 64'h40, 64'h0);
    check_fault("lw40");
    run_req(1'b1, 1'b0, 3'b111, 64'h10, 64'h0);
    check_fault("f3_111");
    run_req(1'b1, 1'b0, 3'b001, 64'h13, 64'h0);
    check_fault("lh_mis");

    run_req(1'b0, 1'b1, 3'b000, 64'h11, 64'h1234_5678_9ABC_DEAB);
    check("sb_rd",    64'(acc_read),  64'd1);
    check("sb_wr0",   64'(acc_write), 64'd0);
    check("sb_wrcyc", 64'(wr_cyc),    64'd1);
    check("sb_wrcnt", 64'(wr_seen),   64'd1);
    check("sb_waddr", wr_addr,        64'h10);
    check("sb_wdata", wr_data,        64'h8877_6655_4433_AB11);
    check("sb_lat",   64'(lat),       64'd2);
    check("sb_flt",   64'(r_fault),   64'd0);
    check("sb_mem",   mem[2],         64'h8877_6655_4433_AB11);

    run_req(1'b0, 1'b1, 3'b011, 64'h21, 64'hFFFF_FFFF_FFFF_FFFF);
    check_fault("sd21");
    check("sd21_mem", mem[4], 64'h0);
    run_req(1'b0, 1'b1, 3'b100, 64'h20, 64'h5);
    check_fault("st_f3");
    run_req(1'b1, 1'b1, 3'b011, 64'h20, 64'h5);
    check_fault("ld_st");

    run_req(1'b0, 1'b1, 3'b011, 64'h28, 64'h0102_0304_0506_0708);
    check("sd28_wr",  64'(acc_write), 64'd1);
    check("sd28_rd",  64'(acc_read),  64'd0);
    check("sd28_lat", 64'(lat),       64'd1);
    check("sd28_mem", mem[5],         64'h0102_0304_0506_0708);

    // sw then lw held valid: lw must wait until the sw response has gone
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 3'b010, 64'h18, 64'hFFFF_FFFF_DEAD_BEEF);
    #1;
    check("b2b_acc", 64'(req_ready), 64'd1);
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 3'b010, 64'h18, 64'h0);
    #1;
    check("b2b_rdy1", 64'(req_ready), 64'd0);
    check("b2b_mw1",  64'(mem_write), 64'd1);
    @(negedge clk);
    #1;
    check("b2b_rdy2", 64'(req_ready),  64'd0);
    check("b2b_rv2",  64'(resp_valid), 64'd1);
    @(negedge clk);
    #1;
    check("b2b_rdy3", 64'(req_ready), 64'd1);
    check("b2b_rd3",  64'(mem_read),  64'd1);
    check("b2b_mem",  mem[3],         64'h0000_0000_DEAD_BEEF);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 3'b000, 64'h0, 64'h0);
    #1;
    check("b2b_rv4",  64'(resp_valid), 64'd1);
    check("b2b_data", load_data,       64'hFFFF_FFFF_DEAD_BEEF);

    // Reset while MERGE_WR is driving the write
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 3'b001, 64'h12, 64'h0000_0000_0000_CAFE);
    #1;
    check("rmw_acc", 64'(req_ready), 64'd1);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 3'b000, 64'h0, 64'h0);
    #1;
    check("rmw_mw", 64'(mem_write), 64'd1);
    reset = 1'b0;
    #1;
    check("rmw_mw0",  64'(mem_write),  64'd0);
    check("rmw_rdy",  64'(req_ready),  64'd1);
    check("rmw_rv",   64'(resp_valid), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    hits = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (resp_valid) hits++;
      @(negedge clk);
    end
    check("rmw_noresp", 64'(hits), 64'd0);
    check("rmw_mem",    mem[2],    64'h8877_6655_4433_AB11);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
